// File: rtl/jerky_step_ctrl_pkg.sv
// Shared definitions for the jerky LED pacing stage: FSM state encodings and switch width.
package jerky_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSE  = 2'd1,
    SINGLE = 2'd2
  } state_e;

  localparam int SPEED_W = 2;

endpackage

// File: rtl/jerky_step_ctrl_if.sv
// Board-side signals of the pacing stage: buttons and speed switch in, step enable and run flag out.
interface jerky_step_ctrl_if;
  import jerky_pkg::*;

  logic               btn_run;
  logic               btn_step;
  logic [SPEED_W-1:0] speed;
  logic               step;
  logic               running;

  modport master (
    output btn_run,
    output btn_step,
    output speed,
    input  step,
    input  running
  );

  modport slave (
    input  btn_run,
    input  btn_step,
    input  speed,
    output step,
    output running
  );

endinterface

// File: rtl/jerky_step_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and a registered rising-edge pulse.
module btn_debounce #(
  parameter int DB_CYCLES = 1_000_000,
  parameter int DB_W      = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

  logic            sync1_q;
  logic            sync2_q;
  logic            level_q;
  logic            level_d;
  logic            level_prev_q;
  logic            press_q;
  logic [DB_W-1:0] cnt_q;
  logic [DB_W-1:0] cnt_d;

  // Any sample agreeing with the accepted level restarts the stability window.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      level_d = sync2_q;
    end else begin
      cnt_d = cnt_q + DB_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= raw;
      sync2_q      <= sync1_q;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/jerky_step_ctrl.sv
// Pacing stage for the jerky LED counter: run/pause/single-step FSM and a speed-scaled step prescaler.
module jerky_step_ctrl
  import jerky_pkg::*;
#(
  parameter int STEP_DIV  = 12_500_000,
  parameter int DIV_W     = 24,
  parameter int DB_CYCLES = 1_000_000,
  parameter int DB_W      = 20
) (
  input  logic              clk,
  input  logic              rst,
  jerky_step_ctrl_if.slave  bus
);

  localparam logic [DIV_W-1:0] STEP_DIV_W = DIV_W'(STEP_DIV);

  logic [1:0]       raw_vec;
  logic [1:0]       press_vec;
  logic             run_press;
  logic             step_press;

  state_e           state_q;
  state_e           state_d;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] limit;
  logic             step_q;
  logic             step_d;
  logic             running_q;
  logic             running_d;

  assign raw_vec = {bus.btn_step, bus.btn_run};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .DB_W      (DB_W)
      ) u_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (raw_vec[gi]),
        .level (),
        .press (press_vec[gi])
      );
    end
  endgenerate

  assign run_press  = press_vec[0];
  assign step_press = press_vec[1];

  // Run press has priority over step press when both land in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (run_press) state_d = PAUSE;
      PAUSE: begin
        if (run_press)       state_d = RUN;
        else if (step_press) state_d = SINGLE;
      end
      SINGLE:  state_d = PAUSE;
      default: state_d = RUN;
    endcase
  end

  // The >= compare lets a mid-count speed increase fire on the next cycle instead of wrapping.
  always_comb begin
    limit  = (STEP_DIV_W >> bus.speed) - DIV_W'(1);
    cnt_d  = '0;
    step_d = (state_q == SINGLE);
    if (state_q == RUN) begin
      if (cnt_q >= limit) begin
        step_d = 1'b1;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      step_q    <= 1'b0;
      running_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      running_q <= running_d;
    end
  end

  assign bus.step    = step_q;
  assign bus.running = running_q;

endmodule

// File: tb/tb_jerky_step_ctrl.sv
// Randomized bench for jerky_step_ctrl: an event-level model predicts step edges into a scoreboard queue.
module tb_jerky_step_ctrl;

  localparam int STEP_DIV  = 8;
  localparam int DIV_W     = 4;
  localparam int DB_CYCLES = 4;
  localparam int DB_W      = 2;
  // Raw edge to accepted press is DB_CYCLES+3 clk; the mode changes on the following edge.
  localparam int PRESS_LAT = DB_CYCLES + 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jerky_step_ctrl_if bus();

  jerky_step_ctrl #(
    .STEP_DIV  (STEP_DIV),
    .DIV_W     (DIV_W),
    .DB_CYCLES (DB_CYCLES),
    .DB_W      (DB_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model modes: 0 running, 1 paused, 2 single step in progress.
  int cyc    = 0;
  int m_mode = 0;
  int m_ref  = 0;
  int exp_q[$];
  int run_evt[$];
  int stp_evt[$];
  int n_checks = 0;
  int n_fail   = 0;
  int lim;
  bit rp, sp;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a step is due once (edges since the last step or RUN entry) exceed the limit.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc    = 0;
      m_mode = 0;
      m_ref  = 0;
      exp_q.delete();
      run_evt.delete();
      stp_evt.delete();
    end else begin
      cyc++;
      lim = (STEP_DIV >> bus.speed) - 1;
      if ((m_mode == 0 && (cyc - 1 - m_ref) >= lim) || m_mode == 2) begin
        exp_q.push_back(cyc);
        if (m_mode == 0) m_ref = cyc;
      end
      rp = 1'b0;
      sp = 1'b0;
      if (run_evt.size() > 0 && run_evt[0] == cyc) begin
        rp = 1'b1;
        void'(run_evt.pop_front());
      end
      if (stp_evt.size() > 0 && stp_evt[0] == cyc) begin
        sp = 1'b1;
        void'(stp_evt.pop_front());
      end
      case (m_mode)
        0: if (rp) m_mode = 1;
        1: begin
          if (rp) begin
            m_mode = 0;
            m_ref  = cyc;
          end else if (sp) begin
            m_mode = 2;
          end
        end
        default: m_mode = 1;
      endcase
    end
  end

  // Monitor: compares outputs every cycle against the scoreboard head and model mode.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_step", int'(bus.step), 0);
      chk("rst_running", int'(bus.running), 1);
    end else begin
      if (exp_q.size() > 0 && exp_q[0] == cyc) begin
        void'(exp_q.pop_front());
        chk("step_expected", int'(bus.step), 1);
      end else begin
        chk("step_unexpected", int'(bus.step), 0);
      end
      chk("running", int'(bus.running), (m_mode == 0) ? 1 : 0);
    end
  end

  task automatic press(input bit do_run, input bit do_step, input int hold);
    if (do_run)  run_evt.push_back(cyc + PRESS_LAT);
    if (do_step) stp_evt.push_back(cyc + PRESS_LAT);
    bus.btn_run  = do_run;
    bus.btn_step = do_step;
    repeat (hold) @(negedge clk);
    bus.btn_run  = 1'b0;
    bus.btn_step = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic glitch(input bit on_run, input int len);
    if (on_run) bus.btn_run = 1'b1;
    else        bus.btn_step = 1'b1;
    repeat (len) @(negedge clk);
    bus.btn_run  = 1'b0;
    bus.btn_step = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic mid_reset();
    bus.btn_run = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_step", int'(bus.step), 0);
    chk("midrst_running", int'(bus.running), 1);
    bus.btn_run = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  initial begin
    bus.btn_run  = 1'b0;
    bus.btn_step = 1'b0;
    bus.speed    = 2'd0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    // Free run at speed 0, then raise speed while the prescaler holds 5.
    repeat (26) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      if (cyc % 8 == 5) break;
      @(negedge clk);
    end
    bus.speed = 2'd2;
    repeat (10) @(negedge clk);
    bus.speed = 2'd0;
    repeat (10) @(negedge clk);

    // Pause, idle, resume.
    press(1'b1, 1'b0, 10);
    repeat (20) @(negedge clk);
    press(1'b1, 1'b0, 6);
    repeat (12) @(negedge clk);

    // Single step in pause, then a short glitch on the step button.
    press(1'b1, 1'b0, 8);
    press(1'b0, 1'b1, 8);
    glitch(1'b0, 2);
    glitch(1'b1, 3);

    // Simultaneous presses while paused, then a step press while running.
    press(1'b1, 1'b1, 8);
    press(1'b0, 1'b1, 8);
    repeat (10) @(negedge clk);

    mid_reset();

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0: bus.speed = 2'($urandom_range(0, 3));
        1: press(1'b1, 1'b0, $urandom_range(DB_CYCLES + 1, 10));
        2: press(1'b0, 1'b1, $urandom_range(DB_CYCLES + 1, 10));
        3: press(1'b1, 1'b1, $urandom_range(DB_CYCLES + 1, 10));
        4: glitch(1'($urandom_range(0, 1)), $urandom_range(1, DB_CYCLES - 1));
        default: repeat ($urandom_range(1, 20)) @(negedge clk);
      endcase
    end

    bus.speed = 2'($urandom_range(0, 3));
    mid_reset();

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("press_events_consumed", run_evt.size() + stp_evt.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
